// File: rtl/fila_pkg.sv
// Shared definitions for the queue and its consumer: FSM state type and timing defaults.
package fila_pkg;

    // Edges from the dequeue sample until queue head data is valid to capture.
    localparam int unsigned LAT_DADO_DEF = 2;
    // Edges from the dequeue sample until the queue's len_out reflects the pop.
    localparam int unsigned LAT_LEN_DEF  = 5;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StReq      = 3'd1,
        StWaitDado = 3'd2,
        StHold     = 3'd3,
        StSettle   = 3'd4
    } fila_cons_state_t;

    // Saturating increment for the latency counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fila_consumidor.sv
// Queue consumer: pops one byte at a time, waits out the queue's data and length latencies,
// and hands each byte downstream with a valid/ready handshake.
module fila_consumidor
    import fila_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned LAT_DADO = LAT_DADO_DEF,
    parameter int unsigned LAT_LEN  = LAT_LEN_DEF
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic              enable_in,
    input  logic [7:0]        len_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [15:0]       consumidos_out
);

    localparam logic [CNT_W-1:0] LatDadoC = CNT_W'(LAT_DADO);
    localparam logic [CNT_W-1:0] LatLenC  = CNT_W'(LAT_LEN);

    fila_cons_state_t  state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [15:0]       cons_q, cons_d;

    // Next-state logic; cnt_d is the counter value after this edge, so the
    // latency tests below fire on the edge where the count is reached.
    always_comb begin
        state_d = state_q;
        cnt_d   = sat_inc(cnt_q);
        data_d  = data_q;
        valid_d = valid_q;
        cons_d  = cons_q;
        case (state_q)
            StIdle: begin
                if (enable_in && (len_in != 8'd0)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                cnt_d   = '0;
                state_d = StWaitDado;
            end
            StWaitDado: begin
                if (cnt_d == LatDadoC) begin
                    data_d  = data_in;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (ready_in) begin
                    valid_d = 1'b0;
                    cons_d  = cons_q + 16'd1;
                    state_d = (cnt_d >= LatLenC) ? StIdle : StSettle;
                end
            end
            StSettle: begin
                // Hold off until len_in has caught up with the pop.
                if (cnt_d >= LatLenC) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_10KHz or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cons_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cons_q  <= cons_d;
        end
    end

    assign dequeue_out    = (state_q == StReq);
    assign data_out       = data_q;
    assign valid_out      = valid_q;
    assign consumidos_out = cons_q;

endmodule

// File: tb/tb_fila_consumidor.sv
// Self-checking bench for fila_consumidor with a behavioural queue and a data scoreboard.
module tb_fila_consumidor;

    localparam int unsigned DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              enable_in;
    logic [7:0]        len_in;
    logic [DATA_W-1:0] data_in;
    logic              dequeue_out;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              ready_in;
    logic [15:0]       consumidos_out;

    fila_consumidor #(
        .DATA_W  (DATA_W),
        .LAT_DADO(2),
        .LAT_LEN (5)
    ) dut (
        .clk_10KHz     (clk),
        .reset         (rst_n),
        .enable_in     (enable_in),
        .len_in        (len_in),
        .data_in       (data_in),
        .dequeue_out   (dequeue_out),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .consumidos_out(consumidos_out)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int                n_vec = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                deq_cnt = 0;
    int                acc_cnt = 0;
    int                deq_time[$];
    logic [7:0]        fifo[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [15:0]       exp_cons = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Queue model and scoreboard, evaluated mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (dequeue_out) begin
            deq_cnt++;
            deq_time.push_back(cyc);
            if (fifo.size() > 0) begin
                data_in = fifo.pop_front();
                exp_q.push_back(data_in);
            end
        end
        if (valid_out && ready_in) begin
            acc_cnt++;
            check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
            check_eq("sb_cons", 32'(consumidos_out), 32'(exp_cons));
            exp_cons = exp_cons + 16'd1;
        end
        len_in = 8'(fifo.size());
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !valid_out; i++) tick(1);
        check_eq(tag, 32'(valid_out), 32'd1);
    endtask

    task automatic wait_acc(input string tag, input int target);
        for (int i = 0; i < 100 && acc_cnt < target; i++) tick(1);
        check_eq(tag, 32'(acc_cnt), 32'(target));
    endtask

    int base_deq;
    int base_acc;
    int base_t;

    initial begin
        rst_n     = 1'b0;
        enable_in = 1'b0;
        ready_in  = 1'b0;
        len_in    = 8'd0;
        data_in   = '0;
        tick(3);
        check_eq("rst_deq", 32'(dequeue_out), 32'd0);
        check_eq("rst_valid", 32'(valid_out), 32'd0);
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_eq("rst_cons", 32'(consumidos_out), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Three preloaded bytes, ready held high.
        base_deq = deq_cnt;
        base_acc = acc_cnt;
        base_t   = deq_time.size();
        fifo.push_back(8'h11);
        fifo.push_back(8'h22);
        fifo.push_back(8'h33);
        enable_in = 1'b1;
        ready_in  = 1'b1;
        wait_acc("s1_acc", base_acc + 3);
        tick(20);
        check_eq("s1_deq_cnt", 32'(deq_cnt - base_deq), 32'd3);
        check_eq("s1_cons", 32'(consumidos_out), 32'd3);
        if (deq_time.size() >= base_t + 3) begin
            check_eq("s1_gap1", 32'(deq_time[base_t+1] - deq_time[base_t]), 32'd7);
            check_eq("s1_gap2", 32'(deq_time[base_t+2] - deq_time[base_t+1]), 32'd7);
        end

        // Empty queue: no requests.
        base_deq = deq_cnt;
        tick(50);
        check_eq("s2_no_deq", 32'(deq_cnt - base_deq), 32'd0);

        // Single byte held while downstream stalls.
        base_deq = deq_cnt;
        base_acc = acc_cnt;
        ready_in = 1'b0;
        fifo.push_back(8'hA5);
        wait_valid("s3_valid_rise");
        for (int i = 0; i < 10; i++) begin
            check_eq("s3_hold_valid", 32'(valid_out), 32'd1);
            check_eq("s3_hold_data", 32'(data_out), 32'hA5);
            tick(1);
        end
        ready_in = 1'b1;
        tick(1);
        check_eq("s3_valid_drop", 32'(valid_out), 32'd0);
        tick(20);
        check_eq("s3_acc", 32'(acc_cnt - base_acc), 32'd1);
        check_eq("s3_deq", 32'(deq_cnt - base_deq), 32'd1);

        // enable_in dropped right after the request: transfer still completes.
        base_deq = deq_cnt;
        base_acc = acc_cnt;
        fifo.push_back(8'h3C);
        for (int i = 0; i < 40 && !dequeue_out; i++) tick(1);
        check_eq("s4_req_seen", 32'(dequeue_out), 32'd1);
        tick(1);
        enable_in = 1'b0;
        fifo.push_back(8'h4D);
        tick(30);
        check_eq("s4_acc", 32'(acc_cnt - base_acc), 32'd1);
        check_eq("s4_deq", 32'(deq_cnt - base_deq), 32'd1);

        // Reset while a byte is held.
        fifo.delete();
        ready_in = 1'b0;
        fifo.push_back(8'h5C);
        tick(1);
        enable_in = 1'b1;
        wait_valid("s5_valid_rise");
        check_eq("s5_hold_data", 32'(data_out), 32'h5C);
        #10;
        rst_n = 1'b0;
        #1;
        check_eq("s5_rst_valid", 32'(valid_out), 32'd0);
        check_eq("s5_rst_data", 32'(data_out), 32'd0);
        check_eq("s5_rst_deq", 32'(dequeue_out), 32'd0);
        check_eq("s5_rst_cons", 32'(consumidos_out), 32'd0);
        exp_q.delete();
        exp_cons = 16'd0;
        base_deq = deq_cnt;
        base_acc = acc_cnt;
        fifo.push_back(8'h61);
        fifo.push_back(8'h62);
        ready_in = 1'b1;
        tick(3);
        check_eq("s5_no_deq_in_rst", 32'(deq_cnt - base_deq), 32'd0);
        rst_n = 1'b1;
        wait_acc("s5_acc", base_acc + 2);
        tick(20);
        check_eq("s5_deq", 32'(deq_cnt - base_deq), 32'd2);
        check_eq("s5_cons", 32'(consumidos_out), 32'd2);
        check_eq("s5_fifo_empty", 32'(fifo.size()), 32'd0);

        // Counter wrap from 0xFFFF.
        enable_in = 1'b0;
        tick(2);
        force dut.cons_q = 16'hFFFF;
        tick(1);
        release dut.cons_q;
        tick(1);
        check_eq("s6_preset", 32'(consumidos_out), 32'hFFFF);
        exp_cons = 16'hFFFF;
        base_acc = acc_cnt;
        fifo.push_back(8'h77);
        enable_in = 1'b1;
        wait_acc("s6_acc", base_acc + 1);
        tick(1);
        check_eq("s6_wrap", 32'(consumidos_out), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
